// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the frame-buffer port scheduler.
package fb_sched_pkg;

  localparam int DATA_W_DEF    = 4;
  localparam int ERR_SCAN_DROP = 0;
  localparam int ERR_WR_OVER   = 1;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_RST_RD,
    CMD_READ,
    CMD_RST_WR,
    CMD_WRITE
  } cmd_e;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Small synchronous FIFO buffering compute-core pixels ahead of the memory port.
module fb_pixel_fifo #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fb_port_scheduler.sv
// Arbitrates the single pixel-stream memory port between the compute core (writes)
// and VGA scanout (reads); one registered command per cycle.
//
// command    | meaning
// CMD_RST_RD | rewind memory read pointer (scanout vsync)
// CMD_READ   | fetch next pixel for scanout
// CMD_RST_WR | rewind memory write pointer once the FIFO has drained
// CMD_WRITE  | pop FIFO head to memory (discarded past end of frame)
// CMD_IDLE   | nothing to do
module fb_port_scheduler
  import fb_sched_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 4800,
  parameter int MEM_RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              px_valid,
  input  logic [DATA_W-1:0] px_data,
  output logic              px_ready,
  input  logic              scan_frame,
  input  logic              scan_req,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_reset_read_ptr,
  output logic              mem_write,
  output logic              mem_reset_write_ptr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              frame_done,
  output logic [1:0]        err_flags
);

  localparam int WC_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(FRAME_PIXELS);

  cmd_e                  cmd_sel;
  logic                  rd_rst_pending;
  logic                  rd_rst_pending_nxt;
  logic [1:0]            rd_pending;
  logic [1:0]            rd_pending_nxt;
  logic                  scan_drop;
  logic                  wr_rst_pending;
  logic [WC_W-1:0]       wr_count;
  logic [MEM_RD_LAT-1:0] rd_pipe;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     fifo_head;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  frame_full;
  logic                  read_issue;
  logic                  wr_strobe;
  logic                  wr_discard;

  assign px_ready   = !fifo_full && !wr_rst_pending;
  assign fifo_push  = px_valid && px_ready;
  assign fifo_pop   = (cmd_sel == CMD_WRITE);
  assign frame_full = (wr_count == WC_FULL);
  assign read_issue = (cmd_sel == CMD_READ);
  assign wr_strobe  = fifo_pop && !frame_full;
  assign wr_discard = fifo_pop && frame_full;

  fb_pixel_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(px_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    cmd_sel = CMD_IDLE;
    if (rd_rst_pending)                   cmd_sel = CMD_RST_RD;
    else if (rd_pending != 2'd0)          cmd_sel = CMD_READ;
    else if (wr_rst_pending && fifo_empty) cmd_sel = CMD_RST_WR;
    else if (!fifo_empty)                 cmd_sel = CMD_WRITE;
  end

  // A scan_frame while a rewind is still pending is merged into it: requests
  // counted since the first pulse are already post-rewind and are kept.
  always_comb begin
    rd_rst_pending_nxt = rd_rst_pending;
    rd_pending_nxt     = rd_pending;
    scan_drop          = 1'b0;
    if (cmd_sel == CMD_RST_RD) rd_rst_pending_nxt = 1'b0;
    if (scan_frame)            rd_rst_pending_nxt = 1'b1;
    if (scan_frame && !rd_rst_pending) begin
      rd_pending_nxt = {1'b0, scan_req};
    end else if (scan_req && !read_issue) begin
      if (rd_pending == 2'd3) scan_drop = 1'b1;
      else                    rd_pending_nxt = rd_pending + 2'd1;
    end else if (!scan_req && read_issue) begin
      rd_pending_nxt = rd_pending - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read            <= 1'b0;
      mem_reset_read_ptr  <= 1'b0;
      mem_write           <= 1'b0;
      mem_reset_write_ptr <= 1'b0;
      mem_wdata           <= '0;
      rd_rst_pending      <= 1'b0;
      rd_pending          <= 2'd0;
      wr_rst_pending      <= 1'b0;
      wr_count            <= '0;
      frame_done          <= 1'b0;
      err_flags           <= 2'b00;
      rd_pipe             <= '0;
      scan_valid          <= 1'b0;
      scan_data           <= '0;
    end else begin
      mem_reset_read_ptr  <= (cmd_sel == CMD_RST_RD);
      mem_read            <= read_issue;
      mem_reset_write_ptr <= (cmd_sel == CMD_RST_WR);
      mem_write           <= wr_strobe;
      if (wr_strobe) mem_wdata <= fifo_head;

      rd_rst_pending <= rd_rst_pending_nxt;
      rd_pending     <= rd_pending_nxt;

      if (frame_start)                 wr_rst_pending <= 1'b1;
      else if (cmd_sel == CMD_RST_WR)  wr_rst_pending <= 1'b0;

      if (cmd_sel == CMD_RST_WR) begin
        wr_count   <= '0;
        frame_done <= 1'b0;
      end else begin
        if (wr_strobe) wr_count <= wr_count + 1'b1;
        frame_done <= frame_full;
      end

      if (scan_drop)  err_flags[ERR_SCAN_DROP] <= 1'b1;
      if (wr_discard) err_flags[ERR_WR_OVER]   <= 1'b1;

      // Pipe is fed from the registered strobe so latency counts from mem_read.
      rd_pipe[0] <= mem_read;
      for (int i = 1; i < MEM_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      scan_valid <= rd_pipe[MEM_RD_LAT-1];
      if (rd_pipe[MEM_RD_LAT-1]) scan_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed and randomized bench for fb_port_scheduler against a queue-based reference model.
module tb_fb_port_scheduler;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int FP    = 8;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          px_valid = 1'b0;
  logic [DW-1:0] px_data = '0;
  logic          px_ready;
  logic          scan_frame = 1'b0;
  logic          scan_req = 1'b0;
  logic [DW-1:0] scan_data;
  logic          scan_valid;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_read;
  logic          mem_reset_read_ptr;
  logic          mem_write;
  logic          mem_reset_write_ptr;
  logic [DW-1:0] mem_wdata;
  logic          frame_done;
  logic [1:0]    err_flags;

  always #5 clk = ~clk;

  fb_port_scheduler #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP), .MEM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .scan_frame(scan_frame), .scan_req(scan_req),
    .scan_data(scan_data), .scan_valid(scan_valid), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_reset_read_ptr(mem_reset_read_ptr),
    .mem_write(mem_write), .mem_reset_write_ptr(mem_reset_write_ptr),
    .mem_wdata(mem_wdata), .frame_done(frame_done), .err_flags(err_flags)
  );

  // Reference model: pending work as plain counters and queues.
  int       q_px[$];
  int       due[$];
  bit       m_rd_rst;
  int       m_rd_cnt;
  bit       m_wr_rst;
  int       m_wr_cnt;
  bit       m_fdone;
  bit [1:0] m_err;
  bit [3:0] m_strobe;     // {read, reset_read_ptr, write, reset_write_ptr}
  int       m_wdata;
  bit       m_sv;
  int       m_sd;
  int       cyc;
  int       n_vec;
  int       n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_px.delete();
    due.delete();
    m_rd_rst = 0; m_rd_cnt = 0; m_wr_rst = 0; m_wr_cnt = 0;
    m_fdone = 0; m_err = 0; m_strobe = 0; m_wdata = 0; m_sv = 0; m_sd = 0;
  endtask

  task automatic check_outputs();
    chk("strobes", {mem_read, mem_reset_read_ptr, mem_write, mem_reset_write_ptr}, m_strobe);
    if (m_strobe[1]) chk("mem_wdata", mem_wdata, m_wdata);
    chk("scan_valid", scan_valid, m_sv);
    if (m_sv) chk("scan_data", scan_data, m_sd);
    chk("px_ready", px_ready, (q_px.size() < DEPTH) && !m_wr_rst);
    chk("frame_done", frame_done, m_fdone);
    chk("err_flags", err_flags, m_err);
  endtask

  // Apply one cycle of inputs, advance the model over the edge, then compare.
  task automatic tick(input bit fs, input bit pv, input int pd, input bit sf, input bit sr);
    int  kind;
    bit  ready;
    bit  at_end;
    int  rdata_now;
    int  v;
    frame_start = fs; px_valid = pv; px_data = DW'(pd); scan_frame = sf; scan_req = sr;
    rdata_now = int'(mem_rdata);
    if (m_rd_rst)                         kind = 1;
    else if (m_rd_cnt > 0)                kind = 2;
    else if (m_wr_rst && q_px.size() == 0) kind = 3;
    else if (q_px.size() > 0)             kind = 4;
    else                                  kind = 0;
    ready  = (q_px.size() < DEPTH) && !m_wr_rst;
    at_end = (m_wr_cnt == FP);

    @(posedge clk);
    #1;
    m_strobe = 4'b0000;
    case (kind)
      1: m_strobe = 4'b0100;
      2: begin m_strobe = 4'b1000; due.push_back(cyc + LAT + 2); end
      3: m_strobe = 4'b0001;
      4: begin
        v = q_px.pop_front();
        if (at_end) m_err[1] = 1'b1;
        else begin m_strobe = 4'b0010; m_wdata = v; end
      end
      default: ;
    endcase
    if (pv && ready) q_px.push_back(pd & ((1 << DW) - 1));
    m_fdone = (kind == 3) ? 1'b0 : at_end;
    if (kind == 3) m_wr_cnt = 0;
    else if (m_strobe[1]) m_wr_cnt++;
    if (fs) m_wr_rst = 1'b1;
    else if (kind == 3) m_wr_rst = 1'b0;
    if (sf && !m_rd_rst) m_rd_cnt = sr;
    else if (sr && kind != 2) begin
      if (m_rd_cnt == 3) m_err[0] = 1'b1;
      else m_rd_cnt++;
    end else if (!sr && kind == 2) m_rd_cnt--;
    if (sf) m_rd_rst = 1'b1;
    else if (kind == 1) m_rd_rst = 1'b0;
    cyc++;
    m_sv = 1'b0;
    if (due.size() > 0 && due[0] == cyc) begin
      void'(due.pop_front());
      m_sv = 1'b1;
      m_sd = rdata_now;
    end
    mem_rdata = DW'($urandom);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    model_reset();
    #2;
    chk("reset_strobes", {mem_read, mem_reset_read_ptr, mem_write, mem_reset_write_ptr}, 4'b0000);
    chk("reset_scan_valid", scan_valid, 1'b0);
    chk("reset_scan_data", scan_data, 4'h0);
    chk("reset_wdata", mem_wdata, 4'h0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_err", err_flags, 2'b00);
    #20 rst_n = 1'b1;
    chk("ready_after_reset", px_ready, 1'b1);

    // Three pixels, no scan traffic.
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 2, 0, 0);
    tick(0, 1, 3, 0, 0);
    idle(4);

    // frame_start with pixels still queued: drain, then rewind writes.
    tick(0, 1, 4, 0, 0);
    tick(1, 1, 5, 0, 0);
    tick(0, 1, 6, 0, 0);
    idle(6);

    // Scan rewind and two fetches racing four queued pixels.
    tick(0, 1, 7, 1, 0);
    tick(0, 1, 8, 0, 1);
    tick(0, 1, 9, 0, 1);
    tick(0, 1, 10, 0, 0);
    idle(8);

    // Fill past the frame end: 8th write sets frame_done, 9th is discarded.
    for (int i = 0; i < 5; i++) tick(0, 1, 11 + i, 0, 0);
    idle(6);

    // scan_frame flood holds the rewind; fourth request overflows.
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 0);
    idle(10);

    // Reset with two reads in flight.
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 5, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {mem_read, mem_reset_read_ptr, mem_write, mem_reset_write_ptr}, 4'b0000);
    chk("midrst_scan_valid", scan_valid, 1'b0);
    chk("midrst_err", err_flags, 2'b00);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("inrst_strobes", {mem_read, mem_reset_read_ptr, mem_write, mem_reset_write_ptr}, 4'b0000);
      chk("inrst_scan_valid", scan_valid, 1'b0);
    end
    #3 rst_n = 1'b1;
    chk("ready_after_midrst", px_ready, 1'b1);
    idle(6);
    tick(0, 1, 12, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
           $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
